// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encodings, instruction opcodes and register widths.
package jtag_pkg;

  localparam int IR_LEN = 4;
  localparam int DR_LEN = 32;

  localparam logic [IR_LEN-1:0] IR_IDCODE   = 4'h1;
  localparam logic [IR_LEN-1:0] IR_USERDATA = 4'h8;
  localparam logic [IR_LEN-1:0] IR_BYPASS   = 4'hF;
  localparam logic [IR_LEN-1:0] IR_CAPTURE  = 4'b0001;

  // Encodings follow the IEEE 1149.1 suggested state assignment.
  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_IDLE       = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_RESET      = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_USER
  } dr_sel_e;

  // Unknown opcodes fall back to BYPASS.
  function automatic dr_sel_e decode_ir(input logic [IR_LEN-1:0] ir);
    dr_sel_e sel;
    case (ir)
      IR_IDCODE:   sel = SEL_IDCODE;
      IR_USERDATA: sel = SEL_USER;
      default:     sel = SEL_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jtag_sync.sv
// Multi-flop synchronizer for one JTAG pin, with rise/fall pulses on the synchronized level.
module jtag_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] stage_reg;
  logic [STAGES:0]   chain;
  logic              q_dly_reg;

  assign chain = {stage_reg, d};
  assign q     = chain[STAGES];

  always_ff @(posedge clk) begin
    if (srst) begin
      stage_reg <= {STAGES{INIT}};
      q_dly_reg <= INIT;
    end else begin
      stage_reg <= chain[STAGES-1:0];
      q_dly_reg <= q;
    end
  end

  assign rise = q & ~q_dly_reg;
  assign fall = ~q & q_dly_reg;

endmodule

// File: rtl/jtag_tap_target.sv
// JTAG TAP oversampled in the CLK domain: IDCODE, USERDATA and BYPASS data registers.
module jtag_tap_target
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0A5F,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TCK,
  input  logic        TMS,
  input  logic        TDI,
  input  logic        nTRST,
  output logic        TDO,
  output logic        TDO_OE,
  output logic        RTCK,
  input  logic [31:0] USER_IN,
  output logic [31:0] USER_OUT,
  output logic        USER_UPDATE,
  output logic [3:0]  TAP_STATE
);

  // Bit order {nTRST, TDI, TMS, TCK}; idle levels TCK=0, TMS=1, nTRST=1.
  localparam logic [3:0] SYNC_INIT = 4'b1010;

  logic [3:0] raw_in;
  logic [3:0] sync_q;
  logic [3:0] sync_rise;
  logic [3:0] sync_fall;
  logic       unused_edges;

  assign raw_in = {nTRST, TDI, TMS, TCK};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      jtag_sync #(
        .STAGES(SYNC_STAGES),
        .INIT  (SYNC_INIT[gi])
      ) u_sync (
        .clk (CLK),
        .srst(RST),
        .d   (raw_in[gi]),
        .q   (sync_q[gi]),
        .rise(sync_rise[gi]),
        .fall(sync_fall[gi])
      );
    end
  endgenerate

  logic tck_s, tms_s, tdi_s, trst_n_s, tck_rise, tck_fall;
  assign tck_s        = sync_q[0];
  assign tms_s        = sync_q[1];
  assign tdi_s        = sync_q[2];
  assign trst_n_s     = sync_q[3];
  assign tck_rise     = sync_rise[0];
  assign tck_fall     = sync_fall[0];
  assign unused_edges = ^{sync_rise[3:1], sync_fall[3:1]};

  tap_state_e state_reg, state_next;

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= TAP_RESET;
    else     state_reg <= state_next;
  end

  // nTRST outranks a coincident TCK rise.
  always_comb begin
    state_next = state_reg;
    if (!trst_n_s) begin
      state_next = TAP_RESET;
    end else if (tck_rise) begin
      unique case (state_reg)
        TAP_RESET:      state_next = tms_s ? TAP_RESET     : TAP_IDLE;
        TAP_IDLE:       state_next = tms_s ? TAP_SELECT_DR : TAP_IDLE;
        TAP_SELECT_DR:  state_next = tms_s ? TAP_SELECT_IR : TAP_CAPTURE_DR;
        TAP_CAPTURE_DR: state_next = tms_s ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
        TAP_SHIFT_DR:   state_next = tms_s ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
        TAP_EXIT1_DR:   state_next = tms_s ? TAP_UPDATE_DR : TAP_PAUSE_DR;
        TAP_PAUSE_DR:   state_next = tms_s ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
        TAP_EXIT2_DR:   state_next = tms_s ? TAP_UPDATE_DR : TAP_SHIFT_DR;
        TAP_UPDATE_DR:  state_next = tms_s ? TAP_SELECT_DR : TAP_IDLE;
        TAP_SELECT_IR:  state_next = tms_s ? TAP_RESET     : TAP_CAPTURE_IR;
        TAP_CAPTURE_IR: state_next = tms_s ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
        TAP_SHIFT_IR:   state_next = tms_s ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
        TAP_EXIT1_IR:   state_next = tms_s ? TAP_UPDATE_IR : TAP_PAUSE_IR;
        TAP_PAUSE_IR:   state_next = tms_s ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
        TAP_EXIT2_IR:   state_next = tms_s ? TAP_UPDATE_IR : TAP_SHIFT_IR;
        TAP_UPDATE_IR:  state_next = tms_s ? TAP_SELECT_DR : TAP_IDLE;
      endcase
    end
  end

  logic [IR_LEN-1:0] ir_shift_reg, ir_reg;
  logic [DR_LEN-1:0] dr_shift_reg;
  logic              bypass_reg;
  logic              tdo_reg, tdo_oe_reg;
  logic [31:0]       user_out_reg;
  logic              user_update_reg;
  dr_sel_e           dr_sel;

  assign dr_sel = decode_ir(ir_reg);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ir_shift_reg    <= '0;
      ir_reg          <= IR_IDCODE;
      dr_shift_reg    <= '0;
      bypass_reg      <= 1'b0;
      tdo_reg         <= 1'b0;
      tdo_oe_reg      <= 1'b0;
      user_out_reg    <= '0;
      user_update_reg <= 1'b0;
    end else begin
      user_update_reg <= 1'b0;
      if (!trst_n_s) begin
        ir_reg     <= IR_IDCODE;
        tdo_oe_reg <= 1'b0;
      end else begin
        if (state_reg == TAP_RESET) ir_reg <= IR_IDCODE;

        // Capture and shift act on the TCK rising edge.
        if (tck_rise) begin
          case (state_reg)
            TAP_CAPTURE_IR: ir_shift_reg <= IR_CAPTURE;
            TAP_SHIFT_IR:   ir_shift_reg <= {tdi_s, ir_shift_reg[IR_LEN-1:1]};
            TAP_CAPTURE_DR: begin
              bypass_reg <= 1'b0;
              if (dr_sel == SEL_IDCODE)    dr_shift_reg <= IDCODE_VALUE;
              else if (dr_sel == SEL_USER) dr_shift_reg <= USER_IN;
            end
            TAP_SHIFT_DR: begin
              bypass_reg   <= tdi_s;
              dr_shift_reg <= {tdi_s, dr_shift_reg[DR_LEN-1:1]};
            end
            default: ;
          endcase
        end

        // Output drive and register updates act on the TCK falling edge.
        if (tck_fall) begin
          tdo_oe_reg <= 1'b0;
          case (state_reg)
            TAP_SHIFT_IR: begin
              tdo_reg    <= ir_shift_reg[0];
              tdo_oe_reg <= 1'b1;
            end
            TAP_SHIFT_DR: begin
              tdo_reg    <= (dr_sel == SEL_BYPASS) ? bypass_reg : dr_shift_reg[0];
              tdo_oe_reg <= 1'b1;
            end
            TAP_UPDATE_IR: ir_reg <= ir_shift_reg;
            TAP_UPDATE_DR: begin
              if (dr_sel == SEL_USER) begin
                user_out_reg    <= dr_shift_reg;
                user_update_reg <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign TDO         = tdo_reg;
  assign TDO_OE      = tdo_oe_reg;
  assign RTCK        = tck_s;
  assign USER_OUT    = user_out_reg;
  assign USER_UPDATE = user_update_reg;
  assign TAP_STATE   = state_reg;

endmodule

// File: doc/jtag_tap_target.md
JTAG_TAP_TARGET -- requirements
Module: jtag_tap_target

Interface
REQ-001 SHALL have parameter IDCODE_VALUE, default 32'h1000_0A5F, the value captured by IDCODE (bit 0 = 1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on TCK/TMS/TDI/nTRST.
REQ-003 SHALL have port CLK, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port TCK, input, 1 bit: JTAG clock from the probe, asynchronous to CLK.
REQ-006 SHALL have port TMS, input, 1 bit: JTAG mode select.
REQ-007 SHALL have port TDI, input, 1 bit: JTAG serial data in.
REQ-008 SHALL have port nTRST, input, 1 bit: JTAG test reset, active low.
REQ-009 SHALL have port TDO, output, 1 bit: JTAG serial data out.
REQ-010 SHALL have port TDO_OE, output, 1 bit: pad enable for TDO, high only while shifting.
REQ-011 SHALL have port RTCK, output, 1 bit: returned clock, equal to the synchronized TCK.
REQ-012 SHALL have port USER_IN, input, 32 bits: core value captured by USERDATA.
REQ-013 SHALL have port USER_OUT, output, 32 bits: last value written through USERDATA.
REQ-014 SHALL have port USER_UPDATE, output, 1 bit: one-CLK pulse when USER_OUT is loaded.
REQ-015 SHALL have port TAP_STATE, output, 4 bits: current TAP state encoding, for debug.

Function
REQ-016 SHALL pass TCK, TMS, TDI and nTRST through SYNC_STAGES flops, then derive one-CLK tck_rise and tck_fall events from the synchronized TCK and its one-cycle-delayed copy.
REQ-017 SHALL require TCK high and low phases of at least SYNC_STAGES+1 CLK periods each; shorter pulses are out of contract.
REQ-018 SHALL, on tck_rise, advance the full 16-state IEEE 1149.1 TAP machine on synchronized TMS and shift the selected register.
REQ-019 SHALL, in Shift-IR/Shift-DR, shift right with TDI entering the MSB.
REQ-020 SHALL use a 4-bit IR with opcodes IDCODE=4'h1, USERDATA=4'h8 and BYPASS=4'hF; every other opcode selects BYPASS.
REQ-021 SHALL load 4'b0001 into the IR shift register in Capture-IR.
REQ-022 SHALL load the selected DR in Capture-DR: IDCODE_VALUE, USER_IN, or 1'b0 for BYPASS.
REQ-023 SHALL, on tck_fall while in Update-IR, copy the IR shift register into the active IR.
REQ-024 SHALL, on tck_fall while in Update-DR with USERDATA active, load USER_OUT and assert USER_UPDATE for exactly that CLK cycle.
REQ-025 SHALL, on tck_fall, set TDO to bit 0 of the selected shift register and TDO_OE=1 when in Shift-IR/Shift-DR, else TDO_OE=0 with TDO holding its value.
REQ-026 SHALL, in Test-Logic-Reset, force the active IR to IDCODE.
REQ-027 SHALL, with synchronized nTRST low, hold the FSM in Test-Logic-Reset regardless of TCK; this takes priority over a simultaneous tck_rise.
REQ-028 SHALL reach Test-Logic-Reset from any state after 5 tck_rise events with TMS=1.

Reset
REQ-029 SHALL, when RST is high, set the FSM to Test-Logic-Reset, IR to IDCODE, TDO=0, TDO_OE=0, USER_OUT=0, USER_UPDATE=0 and all synchronizer flops to TCK=0, TMS=1, nTRST=1.
REQ-030 SHALL, on RST mid-shift, discard the partial shift and leave USER_OUT unchanged by it.

Structure
REQ-031 SHALL place the TAP state typedef/encodings, the IR opcodes and IR_LEN=4 in shared package jtag_pkg.
REQ-032 SHALL instantiate one sub-module, jtag_sync (synchronizer plus edge detect), once per input.

Verification
REQ-033 SHALL show a bench resetting, then driving IR=4'h1 and 32 Shift-DR clocks, reads 32'h1000_0A5F LSB-first on TDO.
REQ-034 SHALL show that with IR=4'hF, a TDI pattern 1,0,1,1 emerges on TDO delayed by exactly one TCK.
REQ-035 SHALL show that USERDATA writing 32'hDEADBEEF gives USER_OUT=32'hDEADBEEF and a single USER_UPDATE pulse, while TDO returns the USER_IN=32'h12345678 captured value.
REQ-036 SHALL show that from Shift-DR, 5 TCKs with TMS=1 yield TAP_STATE=Test-Logic-Reset and IR=IDCODE.
REQ-037 SHALL show that nTRST low mid-Shift-IR gives Test-Logic-Reset within SYNC_STAGES+1 CLKs, TDO_OE=0 and USER_UPDATE never pulsed.
REQ-038 SHALL show that RST asserted during a USERDATA shift leaves USER_OUT=0 and the next IDCODE read correct.
